// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - shared integer register file constants for the RISC-V core
package riscv_defs;

    localparam int          XLEN     = 32;
    localparam int          NREG     = 32;
    localparam int          AW       = $clog2(NREG);
    localparam int          REG_ZERO = 0;
    localparam int          REG_SP   = 2;
    localparam logic [31:0] SP_INIT  = 32'h8000_0FFC;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write scoreboard for the integer register file
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   issue_en/issue_rd  mark a destination as awaiting writeback
//   clr_en/clr_addr    writeback clears the destination's pending bit
//   busy_vec           registered scoreboard (bit 0 always 0)
//   busy_next          next-state scoreboard, used by the read ports
module regfile_scoreboard #(
    parameter int NREG = riscv_defs::NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    output logic [NREG-1:0] busy_vec,
    output logic [NREG-1:0] busy_next
);

    logic [NREG-1:0] busy_q;

    // Issue takes priority over a same-cycle clear: the newly issued producer
    // supersedes the one that is writing back now.
    always_comb begin
        busy_next = busy_q;
        for (int k = 1; k < NREG; k++) begin
            if (issue_en && issue_rd == AW'(k)) begin
                busy_next[k] = 1'b1;
            end else if (clr_en && clr_addr == AW'(k)) begin
                busy_next[k] = 1'b0;
            end
        end
        busy_next[riscv_defs::REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-read-port integer register file with bypass and scoreboard
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   r_en, r_addr              common read enable, packed per-port read addresses
//   r_data, r_busy            registered read data and pending-write bit per port
//   w_en, w_addr, w_data      single write port (writes to x0 dropped)
//   issue_en, issue_rd        mark a destination pending at issue
//   busy_vec                  registered scoreboard
module register_file_mp #(
    parameter int              XLEN    = riscv_defs::XLEN,
    parameter int              NREG    = riscv_defs::NREG,
    parameter int              NRD     = 2,
    parameter int              SP_IDX  = riscv_defs::REG_SP,
    parameter logic [XLEN-1:0] SP_INIT = riscv_defs::SP_INIT,
    localparam int             AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                r_en,
    input  logic [NRD*AW-1:0]   r_addr,
    output logic [NRD*XLEN-1:0] r_data,
    output logic [NRD-1:0]      r_busy,
    input  logic                w_en,
    input  logic [AW-1:0]       w_addr,
    input  logic [XLEN-1:0]     w_data,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_rd,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy_next;

    // regs[0] is reset to zero and never written, so x0 reads as zero even
    // without the explicit read-side check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (w_en && w_addr != '0) begin
            regs[w_addr] <= w_data;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd),
        .clr_en    (w_en),
        .clr_addr  (w_addr),
        .busy_vec  (busy_vec),
        .busy_next (busy_next)
    );

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] rd_val;
        logic [XLEN-1:0] data_q;
        logic            busy_q;

        assign addr = r_addr[p*AW +: AW];

        always_comb begin
            rd_val = regs[addr];
            if (addr == '0) begin
                rd_val = '0;
            end else if (w_en && w_addr == addr) begin
                rd_val = w_data;
            end
        end

        // Busy comes from next state so a read alongside its clearing
        // writeback sees busy=0 together with the bypassed data.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else if (r_en) begin
                data_q <= rd_val;
                busy_q <= busy_next[addr];
            end
        end

        assign r_data[p*XLEN +: XLEN] = data_q;
        assign r_busy[p]              = busy_q;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - directed self-checking bench for register_file_mp
module tb_register_file_mp;

    localparam logic [31:0] SP_VAL = 32'h8000_0FFC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default build: NRD=2, NREG=32, AW=5
    logic        a_r_en = 1'b0;
    logic [9:0]  a_r_addr = '0;
    logic [63:0] a_r_data;
    logic [1:0]  a_r_busy;
    logic        a_w_en = 1'b0;
    logic [4:0]  a_w_addr = '0;
    logic [31:0] a_w_data = '0;
    logic        a_issue_en = 1'b0;
    logic [4:0]  a_issue_rd = '0;
    logic [31:0] a_busy_vec;

    // Alternate build: NRD=3, NREG=16, AW=4
    logic        b_r_en = 1'b0;
    logic [11:0] b_r_addr = '0;
    logic [95:0] b_r_data;
    logic [2:0]  b_r_busy;
    logic        b_w_en = 1'b0;
    logic [3:0]  b_w_addr = '0;
    logic [31:0] b_w_data = '0;
    logic        b_issue_en = 1'b0;
    logic [3:0]  b_issue_rd = '0;
    logic [15:0] b_busy_vec;

    register_file_mp u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .r_en     (a_r_en),
        .r_addr   (a_r_addr),
        .r_data   (a_r_data),
        .r_busy   (a_r_busy),
        .w_en     (a_w_en),
        .w_addr   (a_w_addr),
        .w_data   (a_w_data),
        .issue_en (a_issue_en),
        .issue_rd (a_issue_rd),
        .busy_vec (a_busy_vec)
    );

    register_file_mp #(
        .NRD  (3),
        .NREG (16)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .r_en     (b_r_en),
        .r_addr   (b_r_addr),
        .r_data   (b_r_data),
        .r_busy   (b_r_busy),
        .w_en     (b_w_en),
        .w_addr   (b_w_addr),
        .w_data   (b_w_data),
        .issue_en (b_issue_en),
        .issue_rd (b_issue_rd),
        .busy_vec (b_busy_vec)
    );

    int n_vec     = 0;
    int n_miscmp  = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_read(input logic [4:0] p0, input logic [4:0] p1);
        a_r_en   = 1'b1;
        a_r_addr = {p1, p0};
    endtask

    task automatic a_idle();
        a_r_en     = 1'b0;
        a_w_en     = 1'b0;
        a_issue_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        check("reset_rdata", a_r_data, 0);
        check("reset_busyvec", a_busy_vec, 0);
        rst = 1'b0;

        // Reset values
        a_read(5'd2, 5'd1);
        step();
        check("init_x2", a_r_data[31:0], SP_VAL);
        check("init_x1", a_r_data[63:32], 0);

        // Write then read on both ports
        a_idle();
        a_w_en = 1'b1; a_w_addr = 5'd5; a_w_data = 32'hDEAD_BEEF;
        step();
        a_idle();
        a_read(5'd5, 5'd5);
        step();
        check("wr_x5_p0", a_r_data[31:0], 32'hDEAD_BEEF);
        check("wr_x5_p1", a_r_data[63:32], 32'hDEAD_BEEF);

        // x0 write dropped, including same-cycle bypass attempt
        a_idle();
        a_w_en = 1'b1; a_w_addr = 5'd0; a_w_data = 32'hFFFF_FFFF;
        a_read(5'd0, 5'd5);
        step();
        check("x0_bypass", a_r_data[31:0], 0);
        a_idle();
        a_read(5'd0, 5'd0);
        step();
        check("x0_read_p0", a_r_data[31:0], 0);
        check("x0_read_p1", a_r_data[63:32], 0);

        // Bypass, then hold with r_en=0
        a_idle();
        a_w_en = 1'b1; a_w_addr = 5'd7; a_w_data = 32'h1234_5678;
        a_read(5'd7, 5'd5);
        step();
        check("bypass_x7", a_r_data[31:0], 32'h1234_5678);
        check("bypass_p1_x5", a_r_data[63:32], 32'hDEAD_BEEF);
        a_idle();
        a_r_addr = {5'd0, 5'd1};
        step();
        check("hold_p0", a_r_data[31:0], 32'h1234_5678);
        check("hold_p1", a_r_data[63:32], 32'hDEAD_BEEF);

        // Scoreboard: issue, read busy, writeback with same-cycle read
        a_idle();
        a_issue_en = 1'b1; a_issue_rd = 5'd9;
        step();
        check("issue_x9_vec", a_busy_vec, 32'h0000_0200);
        a_idle();
        a_read(5'd9, 5'd7);
        step();
        check("busy_x9_p0", a_r_busy, 2'b01);
        a_idle();
        a_w_en = 1'b1; a_w_addr = 5'd9; a_w_data = 32'hCAFE_F00D;
        a_read(5'd9, 5'd9);
        step();
        check("wb_x9_busy", a_r_busy, 2'b00);
        check("wb_x9_data", a_r_data[31:0], 32'hCAFE_F00D);
        check("wb_x9_vec", a_busy_vec, 0);

        // Collision: issue and write same register, set wins
        a_idle();
        a_issue_en = 1'b1; a_issue_rd = 5'd4;
        a_w_en = 1'b1; a_w_addr = 5'd4; a_w_data = 32'h0000_0011;
        step();
        check("collide_x4_vec", a_busy_vec, 32'h0000_0010);
        a_idle();
        a_issue_en = 1'b1; a_issue_rd = 5'd0;
        a_read(5'd4, 5'd0);
        step();
        check("issue_x0_vec", a_busy_vec, 32'h0000_0010);
        check("collide_x4_data", a_r_data[31:0], 32'h0000_0011);
        check("collide_x4_busy", a_r_busy, 2'b01);

        // Mid-cycle asynchronous reset, with a write pending
        a_idle();
        a_w_en = 1'b1; a_w_addr = 5'd3; a_w_data = 32'h0000_0055;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rdata", a_r_data, 0);
        check("async_rst_vec", a_busy_vec, 0);
        check("async_rst_rbusy", a_r_busy, 0);
        step();
        check("rst_held_vec", a_busy_vec, 0);
        a_idle();
        rst = 1'b0;
        a_read(5'd2, 5'd1);
        step();
        check("post_rst_x2", a_r_data[31:0], SP_VAL);
        check("post_rst_x1", a_r_data[63:32], 0);
        a_read(5'd31, 5'd4);
        step();
        check("post_rst_x31", a_r_data[31:0], 0);
        check("post_rst_x4", a_r_data[63:32], 0);
        a_idle();

        // Three-port, 16-register build
        b_w_en = 1'b1; b_w_addr = 4'd1; b_w_data = 32'hA5A5_A5A5;
        step();
        b_w_addr = 4'd15; b_w_data = 32'h0F0F_0F0F;
        step();
        b_w_en = 1'b0;
        b_r_en = 1'b1; b_r_addr = {4'd15, 4'd1, 4'd1};
        step();
        check("b_p0_x1", b_r_data[31:0], 32'hA5A5_A5A5);
        check("b_p1_x1", b_r_data[63:32], 32'hA5A5_A5A5);
        check("b_p2_x15", b_r_data[95:64], 32'h0F0F_0F0F);
        b_r_addr = {4'd2, 4'd15, 4'd0};
        step();
        check("b_p0_x0", b_r_data[31:0], 0);
        check("b_p1_x15", b_r_data[63:32], 32'h0F0F_0F0F);
        check("b_p2_x2", b_r_data[95:64], SP_VAL);
        b_r_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
